// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poller.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } nes_state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 60 Hz poll, 12 us latch, 6 us clock phases at 50 MHz
    localparam int POLL_CYCLES_DEF  = 833333;
    localparam int LATCH_CYCLES_DEF = 600;
    localparam int HALF_CYCLES_DEF  = 300;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer with a configurable reset value.
module nes_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_controller_poller.sv
// Periodically latches and shifts in the 8 buttons of an NES controller.
//   state    | meaning
//   IDLE     | waiting for the poll timer tick
//   LATCH    | nesLatch high, controller loads its button register
//   LOW      | nesClk low; data sampled in the last cycle of this phase
//   HIGH     | nesClk high; controller shifts the next button out
//   DONE     | publish shift register to buttons, strobe buttonsValid
module nes_controller_poller
    import nes_pkg::*;
#(
    parameter int POLL_CYCLES  = POLL_CYCLES_DEF,
    parameter int LATCH_CYCLES = LATCH_CYCLES_DEF,
    parameter int HALF_CYCLES  = HALF_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nesData,
    output logic       nesLatch,
    output logic       nesClk,
    output logic [7:0] buttons,
    output logic       buttonsValid,
    output logic       busy
);

    localparam int CNT_MAX = max_int(LATCH_CYCLES, HALF_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TMR_W   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYCLES - 1);

    if (!(POLL_CYCLES > LATCH_CYCLES + 16 * HALF_CYCLES + 4)) begin : g_param_check
        $error("nes_controller_poller: POLL_CYCLES too short for one poll sequence");
    end

    logic             data_sync;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             tick;

    nes_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       buttons_q;
    logic             valid_q;
    logic             latch_q;
    logic             nclk_q;
    logic             busy_q;

    nes_sync #(.RESET_VAL(1'b1)) u_data_sync (
        .clk (clk),
        .rst (reset),
        .d_i (nesData),
        .q_o (data_sync)
    );

    // Free-running poll timer; ticks keep coming while busy and are ignored there.
    assign tick = (timer_q == TMR_LAST);

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (tick) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_LATCH;
                        cnt_q   <= LATCH_LOAD;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_LOW;
                        cnt_q   <= HALF_LOAD;
                        idx_q   <= '0;
                        latch_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == '0) begin
                        shift_q[idx_q] <= ~data_sync;
                        state_q        <= ST_HIGH;
                        cnt_q          <= HALF_LOAD;
                        nclk_q         <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        nclk_q <= 1'b0;
                        cnt_q  <= HALF_LOAD;
                        if (idx_q == 3'(BTN_RIGHT)) begin
                            state_q <= ST_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    buttons_q <= shift_q;
                    valid_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    latch_q <= 1'b0;
                    nclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nesLatch     = latch_q;
    assign nesClk       = nclk_q;
    assign buttons      = buttons_q;
    assign buttonsValid = valid_q;
    assign busy         = busy_q;

endmodule
